// File: rtl/sfx_pkg.sv
// Shared types, table geometry and default note tables for the pong sound-effect sequencer.
package sfx_pkg;

  localparam int unsigned N_SFX      = 3;
  localparam int unsigned MAX_NOTES  = 4;
  localparam int unsigned HALF_W     = 20;
  localparam int unsigned DUR_W      = 8;
  localparam int unsigned SFX_W      = 2;
  localparam int unsigned NOTE_IDX_W = 2;

  typedef enum logic [SFX_W-1:0] {
    SFX_PADDLE = 2'd0,
    SFX_WALL   = 2'd1,
    SFX_SCORE  = 2'd2
  } sfx_e;

  // half_period == 0 terminates an effect's note list
  typedef struct packed {
    logic [HALF_W-1:0] half_period;
    logic [DUR_W-1:0]  dur;
  } note_t;

  typedef note_t      [MAX_NOTES-1:0] sfx_notes_t;
  typedef sfx_notes_t [N_SFX-1:0]     sfx_table_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_DONE
  } state_e;

  // Default tones for a 50 MHz clock and 1 ms ticks
  function automatic sfx_table_t default_table();
    sfx_table_t t;
    t = '0;
    t[0][0] = '{half_period: 20'd54466,  dur: 8'd10};   // paddle ~459 Hz
    t[1][0] = '{half_period: 20'd113636, dur: 8'd16};   // wall   ~220 Hz
    t[2][0] = '{half_period: 20'd113636, dur: 8'd50};   // score  rising arpeggio
    t[2][1] = '{half_period: 20'd75758,  dur: 8'd50};
    t[2][2] = '{half_period: 20'd56818,  dur: 8'd100};
    return t;
  endfunction

  localparam sfx_table_t SFX_TABLE = default_table();

  // Highest set request bit; score outranks wall outranks paddle
  function automatic logic [SFX_W-1:0] top_sfx(input logic [N_SFX-1:0] p);
    logic [SFX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_SFX; i++) begin
      if (p[i]) idx = SFX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sfx_sequencer_tone_gen.sv
// Square-wave tone generator: toggles sq every half_period cycles while enabled.
module tone_gen
  import sfx_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              en,
  input  logic [HALF_W-1:0] half_period,
  output logic              sq
);

  logic [HALF_W-1:0] cnt_q, cnt_d;
  logic              sq_q, sq_d;

  // Half-period counter and output toggle
  always_comb begin
    cnt_d = cnt_q;
    sq_d  = sq_q;
    if (clear || !en) begin
      cnt_d = '0;
      sq_d  = 1'b0;
    end else if (cnt_q == half_period - HALF_W'(1)) begin
      cnt_d = '0;
      sq_d  = ~sq_q;
    end else begin
      cnt_d = cnt_q + HALF_W'(1);
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/sfx_sequencer.sv
// Pong sound-effect sequencer: latches effect requests, grants by fixed priority and
// plays the granted effect's note table through a square-wave tone generator.
// Optional build macro SFX_PREEMPT_EN: a strictly higher-priority pending effect aborts
// the one currently playing (no done pulse for the aborted effect).
module sfx_sequencer
  import sfx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned GAP_TICKS  = 10,
  parameter sfx_table_t  NOTE_TABLE = SFX_TABLE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SFX-1:0] req,
  output logic             busy,
  output logic             done,
  output logic [SFX_W-1:0] cur_sfx,
  output logic             sound
);

  localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TCNT_W   = 16;
  localparam int unsigned GAP_LAST = (GAP_TICKS == 0) ? 0 : GAP_TICKS - 1;

  state_e                state_q, state_d;
  logic [N_SFX-1:0]      pending_q, pending_d;
  logic [SFX_W-1:0]      cur_sfx_q, cur_sfx_d;
  logic [NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  note_t                 note_c;
  logic [DUR_W-1:0]      dur_last_c;
  logic [SFX_W-1:0]      grant_c;
  logic                  tick_c;
  logic                  tone_clear_c;
  logic                  tone_en_c;

  // Current note lookup; a zero duration still plays for one tick
  always_comb begin
    note_c     = NOTE_TABLE[cur_sfx_q][note_idx_q];
    dur_last_c = (note_c.dur == '0) ? '0 : note_c.dur - DUR_W'(1);
    grant_c    = top_sfx(pending_q);
    tick_c     = (presc_q == PRESC_W'(TICK_DIV - 1));
  end

  // Next-state, pending latch, tick counting and output decode
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | req;
    cur_sfx_d    = cur_sfx_q;
    note_idx_d   = note_idx_q;
    presc_d      = presc_q;
    tcnt_d       = tcnt_q;
    tone_clear_c = 1'b0;

    if (state_q == ST_PLAY || state_q == ST_GAP) begin
      presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
      if (tick_c) tcnt_d = tcnt_q + TCNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q != '0) begin
          cur_sfx_d  = grant_c;
          note_idx_d = '0;
          pending_d  = (pending_q & ~(N_SFX'(1) << grant_c)) | req;
          state_d    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (note_c.half_period == '0) begin
          state_d = ST_DONE;
        end else begin
          presc_d      = '0;
          tcnt_d       = '0;
          tone_clear_c = 1'b1;
          state_d      = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick_c && tcnt_q == TCNT_W'(dur_last_c)) begin
          tcnt_d  = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tick_c && tcnt_q == TCNT_W'(GAP_LAST)) begin
          tcnt_d = '0;
          if (note_idx_q == NOTE_IDX_W'(MAX_NOTES - 1)) begin
            state_d = ST_DONE;
          end else begin
            note_idx_d = note_idx_q + NOTE_IDX_W'(1);
            state_d    = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

`ifdef SFX_PREEMPT_EN
    if ((state_q == ST_PLAY || state_q == ST_GAP) && pending_q != '0 && grant_c > cur_sfx_q) begin
      cur_sfx_d  = grant_c;
      note_idx_d = '0;
      tcnt_d     = '0;
      pending_d  = (pending_q & ~(N_SFX'(1) << grant_c)) | req;
      state_d    = ST_LOAD;
    end
`endif

    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    // Dropping enable on the last PLAY cycle silences the speaker exactly as PLAY ends
    tone_en_c = (state_q == ST_PLAY) && (state_d == ST_PLAY);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      cur_sfx_q  <= '0;
      note_idx_q <= '0;
      presc_q    <= '0;
      tcnt_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      cur_sfx_q  <= cur_sfx_d;
      note_idx_q <= note_idx_d;
      presc_q    <= presc_d;
      tcnt_q     <= tcnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  tone_gen u_tone_gen (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (tone_clear_c),
    .en          (tone_en_c),
    .half_period (note_c.half_period),
    .sq          (sound)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign cur_sfx = cur_sfx_q;

endmodule
